// File: rtl/regfile_pkg.sv
// Shared types, default sizes and port-slicing helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned RF_M  = 4;
  localparam int unsigned RF_N  = 15;
  localparam int unsigned RF_W  = 8;
  localparam int unsigned RF_NR = 3;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  // Bit offset of port k inside a flattened address bus of m bits per port.
  function automatic int unsigned addr_of(input int unsigned k, input int unsigned m);
    return k * m;
  endfunction

  // Bit offset of port k inside a flattened data bus of w bits per port.
  function automatic int unsigned data_of(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: walks the word address from 0 to N-1, one word per cycle.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned M = RF_M,
  parameter int unsigned N = RF_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_req,
  output logic         clr_busy,
  output logic [M-1:0] clr_addr
);

  localparam logic [M-1:0] LAST_ADDR = M'(N - 1);

  rf_state_e    state_q, state_d;
  logic [M-1:0] cnt_q, cnt_d;
  logic         busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Requests arriving while a sweep is running are dropped, not queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RF_IDLE:  if (clear_req) state_d = RF_CLEAR;
      RF_CLEAR: if (cnt_q == LAST_ADDR) state_d = RF_IDLE;
      default:  state_d = RF_IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d == RF_CLEAR);
    cnt_d  = '0;
    if (state_q == RF_CLEAR && state_d == RF_CLEAR) cnt_d = cnt_q + M'(1);
  end

  assign clr_busy = busy_q;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised NR-read / 1-write register file with write-first bypass,
// out-of-range protection, read-valid flag and a sequenced bulk clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned M  = RF_M,
  parameter int unsigned N  = RF_N,
  parameter int unsigned W  = RF_W,
  parameter int unsigned NR = RF_NR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ReadEn,
  input  logic [NR*M-1:0] ReadReg,
  input  logic            WriteEn,
  input  logic [M-1:0]    WriteReg,
  input  logic [W-1:0]    WriteData,
  input  logic            ClearReq,
  output logic [NR*W-1:0] ReadData,
  output logic            ReadValid,
  output logic            ClearBusy,
  output logic            WriteDrop
);

  localparam int unsigned MA = M + 1;
  localparam logic [M:0]  N_LIM = MA'(N);

  function automatic logic in_range(input logic [M-1:0] a);
    return {1'b0, a} < N_LIM;
  endfunction

  logic         clr_busy;
  logic [M-1:0] clr_addr;
  logic         wr_ok;
  logic [W-1:0] mem_q [N];
  logic [W-1:0] mem_d [N];
  logic         valid_q, valid_d;
  logic         drop_q, drop_d;

  regfile_clear_seq #(.M(M), .N(N)) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_req(ClearReq),
    .clr_busy (clr_busy),
    .clr_addr (clr_addr)
  );

  // Writes are accepted only outside the clear sweep and only to existing words.
  always_comb begin
    wr_ok   = WriteEn && !clr_busy && in_range(WriteReg);
    drop_d  = WriteEn && !wr_ok;
    valid_d = ReadEn;
    for (int unsigned i = 0; i < N; i++) begin
      mem_d[i] = mem_q[i];
      if (clr_busy && clr_addr == M'(i))     mem_d[i] = '0;
      else if (wr_ok && WriteReg == M'(i))   mem_d[i] = WriteData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) mem_q[i] <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  // Per-port read: clear and write bypass take priority over the stored word.
  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [M-1:0] raddr;
    logic [W-1:0] rd_d, rd_q;

    assign raddr = ReadReg[addr_of(k, M) +: M];

    always_comb begin
      rd_d = rd_q;
      if (ReadEn) begin
        rd_d = '0;
        if (!in_range(raddr) || (clr_busy && raddr == clr_addr)) rd_d = '0;
        else if (wr_ok && raddr == WriteReg)                     rd_d = WriteData;
        else begin
          for (int unsigned i = 0; i < N; i++)
            if (raddr == M'(i)) rd_d = mem_q[i];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= '0;
      else        rd_q <= rd_d;
    end

    assign ReadData[data_of(k, W) +: W] = rd_q;
  end

  assign ReadValid = valid_q;
  assign ClearBusy = clr_busy;
  assign WriteDrop = drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: array-level reference model plus directed vectors.
module tb_regfile_mp;

  localparam int unsigned M  = 4;
  localparam int unsigned N  = 15;
  localparam int unsigned W  = 8;
  localparam int unsigned NR = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ReadEn = 1'b0;
  logic [NR*M-1:0] ReadReg = '0;
  logic            WriteEn = 1'b0;
  logic [M-1:0]    WriteReg = '0;
  logic [W-1:0]    WriteData = '0;
  logic            ClearReq = 1'b0;
  logic [NR*W-1:0] ReadData;
  logic            ReadValid;
  logic            ClearBusy;
  logic            WriteDrop;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_mp #(.M(M), .N(N), .W(W), .NR(NR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ReadEn   (ReadEn),
    .ReadReg  (ReadReg),
    .WriteEn  (WriteEn),
    .WriteReg (WriteReg),
    .WriteData(WriteData),
    .ClearReq (ClearReq),
    .ReadData (ReadData),
    .ReadValid(ReadValid),
    .ClearBusy(ClearBusy),
    .WriteDrop(WriteDrop)
  );

  // Reference model: plain word array, expected outputs, and the word the sweep is on (-1 = none).
  int mem_m [N];
  int exp_rd [NR];
  int exp_valid = 0;
  int exp_drop  = 0;
  int exp_busy  = 0;
  int clear_pos = -1;
  bit started   = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int a, wa;
    bit busy, wok;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem_m[i] = 0;
      for (int k = 0; k < NR; k++) exp_rd[k] = 0;
      exp_valid = 0; exp_drop = 0; exp_busy = 0; clear_pos = -1;
    end else begin
      busy = (clear_pos >= 0);
      wa   = int'(WriteReg);
      wok  = WriteEn && !busy && (wa < N);
      exp_drop  = (WriteEn && !wok) ? 1 : 0;
      exp_valid = ReadEn ? 1 : 0;
      if (ReadEn) begin
        for (int k = 0; k < NR; k++) begin
          a = int'(ReadReg[k*M +: M]);
          if (a >= N)                    exp_rd[k] = 0;
          else if (busy && a == clear_pos) exp_rd[k] = 0;
          else if (wok && a == wa)       exp_rd[k] = int'(WriteData);
          else                           exp_rd[k] = mem_m[a];
        end
      end
      if (busy)     mem_m[clear_pos] = 0;
      else if (wok) mem_m[wa] = int'(WriteData);
      if (busy)          clear_pos = (clear_pos == N - 1) ? -1 : clear_pos + 1;
      else if (ClearReq) clear_pos = 0;
      exp_busy = (clear_pos >= 0) ? 1 : 0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (started && rst_n === 1'b1) begin
      for (int k = 0; k < NR; k++)
        check($sformatf("model_rd%0d", k), 32'(ReadData[k*W +: W]), 32'(exp_rd[k]));
      check("model_valid", 32'(ReadValid), 32'(exp_valid));
      check("model_drop",  32'(WriteDrop), 32'(exp_drop));
      check("model_busy",  32'(ClearBusy), 32'(exp_busy));
    end
  end

  function automatic logic [NR*M-1:0] rr(input int a2, input int a1, input int a0);
    return {M'(a2), M'(a1), M'(a0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ReadEn = 1'b0; WriteEn = 1'b0; ClearReq = 1'b0;
  endtask

  task automatic write_word(input int a, input int d);
    idle_inputs();
    WriteEn = 1'b1; WriteReg = M'(a); WriteData = W'(d);
    step();
    idle_inputs();
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < N; a += 3) begin
      idle_inputs();
      ReadEn = 1'b1; ReadReg = rr(a + 2, a + 1, a);
      step();
      check($sformatf("%s_zero_%0d", tag, a), 32'(ReadData), 32'h0);
    end
    idle_inputs();
  endtask

  task automatic wait_clear(input string tag, output int cnt);
    int guard;
    cnt = 0; guard = 0;
    while (ClearBusy === 1'b1 && guard < 40) begin
      cnt++; guard++;
      step();
    end
    if (guard >= 40) check({tag, "_timeout"}, 32'(guard), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  initial begin : stim
    int cnt, guard;
    rst_n = 1'b0;
    repeat (2) step();
    check("rst_data",  32'(ReadData),  32'h0);
    check("rst_valid", 32'(ReadValid), 32'h0);
    check("rst_busy",  32'(ClearBusy), 32'h0);
    check("rst_drop",  32'(WriteDrop), 32'h0);
    rst_n = 1'b1;
    started = 1'b1;
    step();

    // Read after reset.
    ReadEn = 1'b1; ReadReg = rr(2, 1, 0);
    step();
    check("first_read", 32'(ReadData), 32'h0);
    check("first_valid", 32'(ReadValid), 32'h1);
    idle_inputs();
    step();
    check("valid_drop", 32'(ReadValid), 32'h0);

    // Plain write then read.
    write_word(3, 8'hA5);
    ReadEn = 1'b1; ReadReg = rr(3, 3, 0);
    step();
    check("rd_a5", 32'(ReadData), 32'hA5A500);

    // Write-first bypass on two ports at once.
    write_word(6, 8'h11);
    ReadEn = 1'b1; ReadReg = rr(7, 6, 7);
    WriteEn = 1'b1; WriteReg = 4'd7; WriteData = 8'h5C;
    step();
    check("bypass", 32'(ReadData), 32'h5C115C);
    idle_inputs();

    // Out-of-range write and read.
    write_word(14, 8'h77);
    WriteEn = 1'b1; WriteReg = 4'd15; WriteData = 8'hFF;
    step();
    check("oor_drop", 32'(WriteDrop), 32'h1);
    idle_inputs();
    ReadEn = 1'b1; ReadReg = rr(15, 14, 15);
    step();
    check("oor_read", 32'(ReadData), 32'h007700);
    check("oor_drop_end", 32'(WriteDrop), 32'h0);
    idle_inputs();

    // Fill, then sweep with reads and a blocked write in the middle.
    for (int i = 0; i < N; i++) write_word(i, i + 1);
    ClearReq = 1'b1;
    step();
    ClearReq = 1'b0;
    cnt = 0; guard = 0;
    while (ClearBusy === 1'b1 && guard < 40) begin
      cnt++; guard++;
      WriteEn = (cnt == 5); WriteReg = 4'd2; WriteData = 8'h99;
      ReadEn = 1'b1; ReadReg = rr(14, (cnt < N) ? cnt : 0, cnt - 1);
      step();
      if (cnt == 3) check("clr_bypass", 32'(ReadData), 32'h0F0400);
      if (cnt == 5) check("clr_wdrop", 32'(WriteDrop), 32'h1);
    end
    idle_inputs();
    check("clr_len", 32'(cnt), 32'd15);
    check_all_zero("after_clr");

    // Reset in the middle of a sweep.
    for (int i = 0; i < N; i++) write_word(i, 8'h30 + i);
    ClearReq = 1'b1;
    step();
    ClearReq = 1'b0;
    repeat (3) step();
    check("mid_busy", 32'(ClearBusy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(ClearBusy), 32'h0);
    check("abort_data", 32'(ReadData),  32'h0);
    step();
    rst_n = 1'b1;
    step();
    check_all_zero("after_abort");
    ClearReq = 1'b1;
    step();
    ClearReq = 1'b0;
    check("restart_busy", 32'(ClearBusy), 32'h1);
    wait_clear("restart", cnt);
    check("restart_len", 32'(cnt), 32'd15);

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the fixed three-read/one-write register file.
- Generalised in read-port count, depth and width.
- Adds write-to-read bypass, out-of-range address protection, read-valid flag and a sequenced bulk-clear engine.
- Serves as operand store for datapath units that need several registered reads per cycle.

Parameters:
- M, 4, address bits per port.
- N, 15, number of words (2 <= N <= 2**M; need not be a power of two).
- W, 8, bits per word.
- NR, 3, number of read ports (1..8).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ReadEn  input  1  samples all read addresses this cycle.
- ReadReg  input  NR*M  read addresses; port k at bits [k*M +: M].
- WriteEn  input  1  write request.
- WriteReg  input  M  write address.
- WriteData  input  W  write data.
- ClearReq  input  1  start bulk clear (level-sampled in IDLE only).
- ReadData  output  NR*W  registered read data; port k at bits [k*W +: W].
- ReadValid  output  1  high for one cycle after a cycle with ReadEn=1.
- ClearBusy  output  1  high while the clear sequence runs.
- WriteDrop  output  1  one-cycle pulse: the previous-cycle write was discarded.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all N words, ReadData, ReadValid, WriteDrop go to 0; ClearBusy goes to 0.
  - FSM goes to IDLE; clear counter goes to 0.
  - Reset asserted mid-clear aborts the sequence; array is zero anyway.
- Write:
  - In IDLE with WriteEn=1 and WriteReg < N: word[WriteReg] <= WriteData at the edge.
  - WriteReg >= N: write ignored; WriteDrop=1 next cycle.
- Read:
  - Latency 1. On an edge with ReadEn=1, each port k loads ReadData[k] and ReadValid goes to 1.
  - With ReadEn=0, ReadData holds its value and ReadValid goes to 0.
  - Address >= N returns 0.
- Bypass (write-first):
  - If ReadEn and WriteEn are accepted in the same cycle and ReadReg[k] == WriteReg (< N), ReadData[k] gets WriteData, not the old word.
  - Applies independently to every port; several ports may bypass at once.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when ClearReq=1. Counter=0; ClearBusy=1 from the next cycle.
  - In CLEAR, each cycle: word[counter] <= 0, counter++.
  - On the cycle where counter == N-1, that word is cleared and the FSM returns to IDLE. ClearBusy is therefore high for exactly N cycles.
  - ClearReq is ignored while in CLEAR; no queuing.
  - WriteEn=1 in CLEAR: write discarded, WriteDrop=1 next cycle.
  - Reads are allowed in CLEAR and return current contents. A read of the word being cleared in that same cycle returns 0 (clear bypass).
  - If ClearReq and WriteEn are both high in IDLE, the write is performed that cycle and clearing starts next cycle. The written word is later cleared.
- Widths:
  - All comparisons are on M bits.
  - Counter is M bits and never exceeds N-1.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package regfile_pkg:
  - FSM state enum (RF_IDLE, RF_CLEAR).
  - Default parameter constants.
  - Helper function for port slicing: addr_of(k), data_of(k).
- One natural sub-module: regfile_clear_seq.
  - Contains the FSM, counter and ClearBusy.
  - Outputs clr_en/clr_addr to the array write mux.
- Array, bypass and read ports stay in regfile_mp, built with a generate loop over NR.

Test Plan:
- Reset, then ReadEn with ReadReg={2,1,0} -> ReadData all 0x00; ReadValid=1 one cycle later.
- Write 0xA5 to addr 3; next cycle read ports {3,3,0} -> {0xA5,0xA5,0x00} after 1 cycle.
- Same cycle: write 0x5C to addr 7 and read ports {7,6,7} (6 holds 0x11) -> {0x5C,0x11,0x5C}; no stale 0xA5-style old value.
- N=15: write 0xFF to addr 15 -> WriteDrop pulses; read addr 15 -> 0x00; addr 14 unchanged.
- Fill words 0..14 with i+1, pulse ClearReq:
  - ClearBusy high exactly 15 cycles.
  - WriteEn at cycle 5 of clear -> WriteDrop pulses and the write has no effect.
  - Afterward every word reads 0x00.
- Assert rst_n low at cycle 4 of a clear -> ClearBusy drops immediately; all words 0; FSM accepts a new ClearReq after release.
